rf_writeback: RTL and testbench

Write-port driver for the CPU's 32-entry register file: the producer end of its write interface. It accepts ALU results and memory load responses, arbitrates them onto the single register-file write port, and buffers ALU results that lose arbitration. It also keeps a pending-load scoreboard so the decode stage can stall on outstanding loads. It sits between the execute/memory stages and the register file.

---
 rtl/rf_writeback_if.sv | 24 ++
 rtl/rf_writeback.sv | 145 ++++++++++++++
 tb/tb_rf_writeback.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_writeback_if.sv
// ALU result handshake into the register-file writeback block.
// The master offers a result; the slave (rf_writeback) returns ready.
interface rf_writeback_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    modport master (
        output alu_valid,
        output alu_rd,
        output alu_data,
        input  alu_ready
    );

    modport slave (
        input  alu_valid,
        input  alu_rd,
        input  alu_data,
        output alu_ready
    );
endinterface

// File: rtl/rf_writeback.sv
// Register-file write-port driver: arbitrates load responses over buffered ALU
// results and tracks outstanding loads in a scoreboard for decode stalls.
module rf_writeback #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_writeback_if.slave        alu,
    input  logic                 ld_issue,
    input  logic [4:0]           ld_rd,
    input  logic                 mem_valid,
    input  logic [4:0]           mem_rd,
    input  logic [XLEN-1:0]      mem_data,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [4:0]           dec_rd,
    output logic                 stall,
    output logic [4:0]           wrReg,
    output logic [XLEN-1:0]      wrData,
    output logic                 writeEnable,
    output logic                 mem_writeEnable,
    output logic [31:0]          busy,
    output logic                 wb_err
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = AW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [4:0]      fifo_rd_q   [DEPTH];
    logic [4:0]      fifo_rd_d   [DEPTH];
    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [XLEN-1:0] fifo_data_d [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [4:0]      wr_reg_q, wr_reg_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic            alu_we_q, alu_we_d;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     busy_q, busy_d;
    logic            wb_err_q, wb_err_d;

    logic ready;
    logic push;
    logic pop;

    // Ready uses the pre-pop count, so a full buffer never accepts on a draining cycle.
    // Held low during reset so every output reads zero while rst is asserted.
    assign ready = rst && (count_q < FullCnt);
    assign push  = alu.alu_valid && ready;
    assign pop   = !mem_valid && (count_q != '0);

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_rd_d[wptr_q]   = alu.alu_rd;
            fifo_data_d[wptr_q] = alu.alu_data;
            wptr_d              = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        alu_we_d  = 1'b0;
        mem_we_d  = 1'b0;
        if (mem_valid) begin
            wr_reg_d  = mem_rd;
            wr_data_d = mem_data;
            mem_we_d  = (mem_rd != 5'd0);
        end else if (pop) begin
            wr_reg_d  = fifo_rd_q[rptr_q];
            wr_data_d = fifo_data_q[rptr_q];
            alu_we_d  = (fifo_rd_q[rptr_q] != 5'd0);
        end
    end

    // Set after clear so a same-cycle issue and response to one register stays busy.
    always_comb begin
        busy_d = busy_q;
        if (mem_valid) begin
            busy_d[mem_rd] = 1'b0;
        end
        if (ld_issue) begin
            busy_d[ld_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        wb_err_d  = wb_err_q || (mem_valid && !busy_q[mem_rd] && (mem_rd != 5'd0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            alu_we_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            busy_q    <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
            alu_we_q    <= alu_we_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
            wb_err_q    <= wb_err_d;
        end
    end

    assign alu.alu_ready   = ready;
    assign stall           = busy_q[rs1] || busy_q[rs2] || busy_q[dec_rd];
    assign wrReg           = wr_reg_q;
    assign wrData          = wr_data_q;
    assign writeEnable     = alu_we_q;
    assign mem_writeEnable = mem_we_q;
    assign busy            = busy_q;
    assign wb_err          = wb_err_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: reset, ALU path, load contention,
// scoreboard, x0 suppression and spurious-response error.
module tb_rf_writeback;

    logic        clk;
    logic        rst;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [4:0]  rs1, rs2, dec_rd;
    logic        stall;
    logic [4:0]  wrReg;
    logic [31:0] wrData;
    logic        writeEnable;
    logic        mem_writeEnable;
    logic [31:0] busy;
    logic        wb_err;

    int checks;
    int errors;

    rf_writeback_if #(.XLEN(32)) alu_if ();

    rf_writeback #(.XLEN(32), .DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .alu             (alu_if),
        .ld_issue        (ld_issue),
        .ld_rd           (ld_rd),
        .mem_valid       (mem_valid),
        .mem_rd          (mem_rd),
        .mem_data        (mem_data),
        .rs1             (rs1),
        .rs2             (rs2),
        .dec_rd          (dec_rd),
        .stall           (stall),
        .wrReg           (wrReg),
        .wrData          (wrData),
        .writeEnable     (writeEnable),
        .mem_writeEnable (mem_writeEnable),
        .busy            (busy),
        .wb_err          (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b0;
        alu_if.alu_valid = 1'b0;
        alu_if.alu_rd    = 5'd0;
        alu_if.alu_data  = 32'd0;
        ld_issue  = 1'b0;
        ld_rd     = 5'd0;
        mem_valid = 1'b0;
        mem_rd    = 5'd0;
        mem_data  = 32'd0;
        rs1       = 5'd0;
        rs2       = 5'd0;
        dec_rd    = 5'd0;

        // Power-on reset
        #12;
        check("rst_wrReg", {27'd0, wrReg}, 32'd0);
        check("rst_wrData", wrData, 32'd0);
        check("rst_we", {31'd0, writeEnable}, 32'd0);
        check("rst_mem_we", {31'd0, mem_writeEnable}, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_wb_err", {31'd0, wb_err}, 32'd0);
        check("rst_ready", {31'd0, alu_if.alu_ready}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, alu_if.alu_ready}, 32'd1);

        // Single ALU write: accepted at edge 0, strobe after edge 1
        alu_if.alu_valid = 1'b1;
        alu_if.alu_rd    = 5'd3;
        alu_if.alu_data  = 32'hDEADBEEF;
        tick();
        alu_if.alu_valid = 1'b0;
        check("alu1_we_e0", {31'd0, writeEnable}, 32'd0);
        tick();
        check("alu1_we_e1", {31'd0, writeEnable}, 32'd1);
        check("alu1_wrReg", {27'd0, wrReg}, 32'd3);
        check("alu1_wrData", wrData, 32'hDEADBEEF);
        check("alu1_mem_we", {31'd0, mem_writeEnable}, 32'd0);
        tick();
        check("alu1_we_e2", {31'd0, writeEnable}, 32'd0);
        check("alu1_hold_data", wrData, 32'hDEADBEEF);

        // Contention: three load responses to x7 delay ALU results x1..x3
        ld_issue = 1'b1;
        ld_rd    = 5'd7;
        tick();
        mem_valid = 1'b1;
        mem_rd    = 5'd7;
        mem_data  = 32'h55;
        alu_if.alu_valid = 1'b1;
        alu_if.alu_rd    = 5'd1;
        alu_if.alu_data  = 32'h11;
        tick();
        check("cont1_mem_we", {31'd0, mem_writeEnable}, 32'd1);
        check("cont1_we", {31'd0, writeEnable}, 32'd0);
        check("cont1_wrReg", {27'd0, wrReg}, 32'd7);
        alu_if.alu_rd   = 5'd2;
        alu_if.alu_data = 32'h22;
        tick();
        check("cont2_mem_we", {31'd0, mem_writeEnable}, 32'd1);
        check("cont2_ready", {31'd0, alu_if.alu_ready}, 32'd0);
        ld_issue        = 1'b0;
        alu_if.alu_rd   = 5'd3;
        alu_if.alu_data = 32'h33;
        tick();
        check("cont3_mem_we", {31'd0, mem_writeEnable}, 32'd1);
        check("cont3_wrData", wrData, 32'h55);
        check("cont3_ready", {31'd0, alu_if.alu_ready}, 32'd0);
        check("cont3_busy7", {31'd0, busy[7]}, 32'd0);
        mem_valid = 1'b0;
        tick();
        check("cont4_we", {31'd0, writeEnable}, 32'd1);
        check("cont4_mem_we", {31'd0, mem_writeEnable}, 32'd0);
        check("cont4_wrReg", {27'd0, wrReg}, 32'd1);
        check("cont4_wrData", wrData, 32'h11);
        check("cont4_ready", {31'd0, alu_if.alu_ready}, 32'd1);
        tick();
        alu_if.alu_valid = 1'b0;
        check("cont5_wrReg", {27'd0, wrReg}, 32'd2);
        check("cont5_wrData", wrData, 32'h22);
        tick();
        check("cont6_we", {31'd0, writeEnable}, 32'd1);
        check("cont6_wrReg", {27'd0, wrReg}, 32'd3);
        check("cont6_wrData", wrData, 32'h33);
        tick();
        check("cont7_we", {31'd0, writeEnable}, 32'd0);
        check("cont_wb_err", {31'd0, wb_err}, 32'd0);

        // Scoreboard
        ld_issue = 1'b1;
        ld_rd    = 5'd9;
        rs1      = 5'd9;
        #1;
        check("sb_stall_pre", {31'd0, stall}, 32'd0);
        tick();
        ld_issue = 1'b0;
        check("sb_stall_rs1", {31'd0, stall}, 32'd1);
        check("sb_busy", busy, 32'h0000_0200);
        rs1 = 5'd0;
        rs2 = 5'd9;
        #1;
        check("sb_stall_rs2", {31'd0, stall}, 32'd1);
        rs2    = 5'd0;
        dec_rd = 5'd9;
        #1;
        check("sb_stall_rd", {31'd0, stall}, 32'd1);
        mem_valid = 1'b1;
        mem_rd    = 5'd9;
        mem_data  = 32'h99;
        tick();
        mem_valid = 1'b0;
        check("sb_clr_busy9", {31'd0, busy[9]}, 32'd0);
        check("sb_clr_stall", {31'd0, stall}, 32'd0);
        check("sb_mem_we", {31'd0, mem_writeEnable}, 32'd1);
        check("sb_wrReg", {27'd0, wrReg}, 32'd9);
        ld_issue = 1'b1;
        tick();
        mem_valid = 1'b1;
        tick();
        ld_issue = 1'b0;
        check("sb_set_wins", {31'd0, busy[9]}, 32'd1);
        check("sb_no_err", {31'd0, wb_err}, 32'd0);
        tick();
        mem_valid = 1'b0;
        dec_rd    = 5'd0;
        check("sb_final_clr", busy, 32'd0);

        // x0 suppression
        alu_if.alu_valid = 1'b1;
        alu_if.alu_rd    = 5'd0;
        alu_if.alu_data  = 32'hAA;
        ld_issue = 1'b1;
        ld_rd    = 5'd0;
        tick();
        alu_if.alu_valid = 1'b0;
        ld_issue  = 1'b0;
        mem_valid = 1'b1;
        mem_rd    = 5'd0;
        check("x0_ld_busy", busy, 32'd0);
        tick();
        mem_valid = 1'b0;
        check("x0_mem_we", {31'd0, mem_writeEnable}, 32'd0);
        check("x0_mem_err", {31'd0, wb_err}, 32'd0);
        alu_if.alu_valid = 1'b1;
        alu_if.alu_rd    = 5'd4;
        alu_if.alu_data  = 32'h44;
        tick();
        alu_if.alu_valid = 1'b0;
        check("x0_alu_we", {31'd0, writeEnable}, 32'd0);
        tick();
        check("x0_next_we", {31'd0, writeEnable}, 32'd1);
        check("x0_next_wrReg", {27'd0, wrReg}, 32'd4);
        check("x0_next_wrData", wrData, 32'h44);

        // Spurious response
        mem_valid = 1'b1;
        mem_rd    = 5'd12;
        mem_data  = 32'hC0;
        tick();
        mem_valid = 1'b0;
        check("spur_mem_we", {31'd0, mem_writeEnable}, 32'd1);
        check("spur_wrReg", {27'd0, wrReg}, 32'd12);
        check("spur_err", {31'd0, wb_err}, 32'd1);
        tick();
        tick();
        check("spur_err_sticky", {31'd0, wb_err}, 32'd1);

        // Reset mid-stream with two buffered entries and busy[5] set
        ld_issue = 1'b1;
        ld_rd    = 5'd5;
        tick();
        ld_issue  = 1'b0;
        mem_valid = 1'b1;
        mem_rd    = 5'd0;
        alu_if.alu_valid = 1'b1;
        alu_if.alu_rd    = 5'd10;
        alu_if.alu_data  = 32'hA0;
        tick();
        alu_if.alu_rd   = 5'd11;
        alu_if.alu_data = 32'hB0;
        tick();
        mem_valid        = 1'b0;
        alu_if.alu_valid = 1'b0;
        check("mid_full", {31'd0, alu_if.alu_ready}, 32'd0);
        check("mid_busy5", {31'd0, busy[5]}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_wrReg", {27'd0, wrReg}, 32'd0);
        check("mid_rst_wrData", wrData, 32'd0);
        check("mid_rst_we", {31'd0, writeEnable}, 32'd0);
        check("mid_rst_mem_we", {31'd0, mem_writeEnable}, 32'd0);
        check("mid_rst_busy", busy, 32'd0);
        check("mid_rst_err", {31'd0, wb_err}, 32'd0);
        check("mid_rst_ready", {31'd0, alu_if.alu_ready}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("rel_ready", {31'd0, alu_if.alu_ready}, 32'd1);
        check("rel_we0", {31'd0, writeEnable | mem_writeEnable}, 32'd0);
        tick();
        check("rel_we1", {31'd0, writeEnable | mem_writeEnable}, 32'd0);
        tick();
        check("rel_we2", {31'd0, writeEnable | mem_writeEnable}, 32'd0);
        check("rel_wrReg", {27'd0, wrReg}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
